ctrl_banco_jk: RTL

Sequencing controller for a WIDTH-bit bank of master-slave JK flip-flops with preset/clear. It accepts register commands (load, increment, decrement, shift, clear, set) over a valid/ready handshake. It derives per-bit J/K excitation from the bank's current Q, drives the bank one step at a time, and checks every step against the expected value. It sits between the datapath control logic and the JK register bank, which is the only block that drives the bank's j/k/pr/clr pins.

---
 rtl/ctrl_banco_jk_pkg.sv | 28 ++
 rtl/ctrl_banco_jk_exc_jk.sv | 15 +
 rtl/ctrl_banco_jk.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ctrl_banco_jk_pkg.sv
// Shared definitions for the JK register-bank sequencer: op-codes, FSM states
// and the op legality test.
package ctrl_banco_jk_pkg;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_INC  = 3'd1;
  localparam logic [2:0] OP_DEC  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_CLR  = 3'd4;
  localparam logic [2:0] OP_SET  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [2:0] op);
    return op <= OP_SET;
  endfunction

  // Only the counting/shifting ops honour the repetition count.
  function automatic logic is_repeat(input logic [2:0] op);
    return (op == OP_INC) || (op == OP_DEC) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/ctrl_banco_jk_exc_jk.sv
// Per-bit JK excitation: drive J where a bit must rise, K where it must fall,
// and leave bits that already match untouched (never toggle).
module exc_jk #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] tgt,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  assign j = tgt & ~q;
  assign k = ~tgt & q;

endmodule

// File: rtl/ctrl_banco_jk.sv
// Command sequencer for a JK flip-flop bank: accepts one command over
// cmd_valid/cmd_ready, steps the bank APPLY/CHECK per step and flags mismatches.
module ctrl_banco_jk
  import ctrl_banco_jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [REP_W-1:0] cmd_rep,
  input  logic [WIDTH-1:0] q_bank,
  output logic [WIDTH-1:0] j_bank,
  output logic [WIDTH-1:0] k_bank,
  output logic             pr_bank,
  output logic             clr_bank,
  output logic             busy,
  output logic             done,
  output logic             erro,
  output state_t           dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is low from accept through DONE, and a
  // command offered meanwhile is dropped, not queued.

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [REP_W-1:0] rem;
  logic [WIDTH-1:0] tgt;

  logic [2:0]       op_sel;
  logic [WIDTH-1:0] data_sel;
  logic [WIDTH-1:0] tgt_calc;
  logic [WIDTH-1:0] j_calc;
  logic [WIDTH-1:0] k_calc;

  function automatic logic [WIDTH-1:0] target(input logic [2:0] op,
                                              input logic [WIDTH-1:0] q,
                                              input logic [WIDTH-1:0] d);
    case (op)
      OP_LOAD: return d;
      OP_INC:  return q + ONE;
      OP_DEC:  return q - ONE;
      OP_SHL:  return {q[WIDTH-2:0], d[0]};
      OP_SET:  return '1;
      default: return '0;
    endcase
  endfunction

  // In IDLE the target comes from the offered command; later steps reuse the
  // latched command but always start from the bank's actual Q.
  assign op_sel   = (state == ST_IDLE) ? cmd_op   : op_r;
  assign data_sel = (state == ST_IDLE) ? cmd_data : data_r;
  assign tgt_calc = target(op_sel, q_bank, data_sel);

  exc_jk #(.WIDTH(WIDTH)) u_exc (
    .q   (q_bank),
    .tgt (tgt_calc),
    .j   (j_calc),
    .k   (k_calc)
  );

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      erro      <= 1'b0;
      j_bank    <= '0;
      k_bank    <= '0;
      pr_bank   <= 1'b0;
      clr_bank  <= 1'b0;
      rem       <= '0;
      op_r      <= OP_LOAD;
      data_r    <= '0;
      tgt       <= '0;
    end else begin
      j_bank   <= '0;
      k_bank   <= '0;
      pr_bank  <= 1'b0;
      clr_bank <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_r      <= cmd_op;
            data_r    <= cmd_data;
            rem       <= is_repeat(cmd_op) ? cmd_rep : '0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            tgt       <= tgt_calc;
            if (!is_legal(cmd_op)) begin
              state <= ST_DONE;
              done  <= 1'b1;
              erro  <= 1'b1;
            end else begin
              state <= ST_APPLY;
              erro  <= 1'b0;
              if (cmd_op == OP_CLR) begin
                clr_bank <= 1'b1;
              end else if (cmd_op == OP_SET) begin
                pr_bank <= 1'b1;
              end else begin
                j_bank <= j_calc;
                k_bank <= k_calc;
              end
            end
          end
        end
        ST_APPLY: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (q_bank != tgt) erro <= 1'b1;
          // Only INC/DEC/SHL can have steps left, so J/K is always right here.
          if (rem != '0) begin
            rem    <= rem - REP_W'(1);
            tgt    <= tgt_calc;
            j_bank <= j_calc;
            k_bank <= k_calc;
            state  <= ST_APPLY;
          end else begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
